// File: rtl/timer_irq_arbiter.sv
// Arbitrates the timer interrupt sources onto one CPU request line and vectors it.
// Drives a one-cycle flag clear after the acknowledge and aborts stalled REQ/WAIT stays on timeout.
module timer_irq_arbiter #(
    parameter int NUM_SRC     = 6,
    parameter int VEC_WIDTH   = 3,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_SRC-1:0]   i_irq_src,
    input  logic [NUM_SRC-1:0]   i_irq_en,
    input  logic                 i_rr_en,
    input  logic                 i_irq_ack,
    output logic                 o_irq_req,
    output logic [VEC_WIDTH-1:0] o_irq_vec,
    output logic [NUM_SRC-1:0]   o_flag_clr,
    output logic                 o_timeout_err,
    output logic                 o_busy
);

    localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [VEC_WIDTH-1:0] LAST_IDX = VEC_WIDTH'(NUM_SRC - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_CLR, S_WAIT} state_t;

    state_t               r_state, w_state_nxt;
    logic [VEC_WIDTH-1:0] r_grant, r_rr_ptr, w_winner, w_grant_inc;
    logic [TW-1:0]        r_timer;
    logic                 r_timeout_err;
    logic [NUM_SRC-1:0]   w_pending, w_grant_oh;
    logic                 w_timer_hit, w_load_grant, w_adv_ptr, w_timeout;

    // First pending index at or after base, wrapping; base=0 gives fixed priority.
    function automatic logic [VEC_WIDTH-1:0] pick(input logic [NUM_SRC-1:0] req, input int base);
        logic [VEC_WIDTH-1:0] win;
        logic                 found;
        int                   idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = base + i;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!found && req[idx]) begin
                win   = VEC_WIDTH'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign w_pending   = i_irq_src & i_irq_en;
    assign w_grant_oh  = NUM_SRC'(1) << r_grant;
    assign w_grant_inc = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;
    assign w_timer_hit = (ACK_TIMEOUT != 0) && (r_timer == TW'(ACK_TIMEOUT));
    assign w_winner    = pick(w_pending, i_rr_en ? int'(r_rr_ptr) : 0);

    always_comb begin
        w_state_nxt  = r_state;
        w_load_grant = 1'b0;
        w_adv_ptr    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_pending) begin
                    w_state_nxt  = S_REQ;
                    w_load_grant = 1'b1;
                end
            end
            S_REQ: begin
                // Ack beats withdrawal, withdrawal beats timeout.
                if (i_irq_ack) begin
                    w_state_nxt = S_CLR;
                end else if (!(|(w_pending & w_grant_oh))) begin
                    w_state_nxt = S_IDLE;
                end else if (w_timer_hit) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                    w_adv_ptr   = 1'b1;
                end
            end
            S_CLR: begin
                w_state_nxt = S_WAIT;
                w_adv_ptr   = 1'b1;
            end
            S_WAIT: begin
                if (!(|(i_irq_src & w_grant_oh))) begin
                    w_state_nxt = S_IDLE;
                end else if (w_timer_hit) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant       <= '0;
            r_rr_ptr      <= '0;
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (w_load_grant) r_grant <= w_winner;
            if (w_adv_ptr) r_rr_ptr <= w_grant_inc;
            if ((w_state_nxt != r_state) || (ACK_TIMEOUT == 0)) begin
                r_timer <= '0;
            end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign o_irq_req     = (r_state == S_REQ);
    assign o_irq_vec     = o_irq_req ? r_grant : '0;
    assign o_flag_clr    = (r_state == S_CLR) ? w_grant_oh : '0;
    assign o_timeout_err = r_timeout_err;
    assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_timer_irq_arbiter.sv
// Directed bench for timer_irq_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_timer_irq_arbiter;

    logic       clk;
    logic       rst_n;
    logic [5:0] irq_src;
    logic [5:0] irq_en;
    logic       rr_en;
    logic       irq_ack;
    logic       irq_req;
    logic [2:0] irq_vec;
    logic [5:0] flag_clr;
    logic       timeout_err;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;

    timer_irq_arbiter #(
        .NUM_SRC    (6),
        .VEC_WIDTH  (3),
        .ACK_TIMEOUT(8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_irq_src    (irq_src),
        .i_irq_en     (irq_en),
        .i_rr_en      (rr_en),
        .i_irq_ack    (irq_ack),
        .o_irq_req    (irq_req),
        .o_irq_vec    (irq_vec),
        .o_flag_clr   (flag_clr),
        .o_timeout_err(timeout_err),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        #12;
        n_checks++;
        if ({irq_req, irq_vec, flag_clr, timeout_err, busy} !== 12'h000) begin
            n_fails++;
            $display("FAIL reset_outputs: got req=%0b vec=%0d clr=%b to=%0b busy=%0b, expected all 0",
                     irq_req, irq_vec, flag_clr, timeout_err, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || irq_req !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_idle: got busy=%0b req=%0b, expected 0 0", busy, irq_req);
        end
    endtask

    task automatic test_fixed_priority;
        rr_en   = 1'b0;
        irq_en  = 6'h3F;
        irq_src = 6'b100100;
        @(negedge clk);
        n_checks++;
        if (irq_req !== 1'b1 || irq_vec !== 3'd2) begin
            n_fails++;
            $display("FAIL fixed_first: got req=%0b vec=%0d, expected 1 2", irq_req, irq_vec);
        end
        irq_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (flag_clr !== 6'b000100 || irq_req !== 1'b0) begin
            n_fails++;
            $display("FAIL fixed_clr: got clr=%b req=%0b, expected 000100 0", flag_clr, irq_req);
        end
        irq_ack = 1'b0;
        irq_src = 6'b100000;
        @(negedge clk);
        n_checks++;
        if (flag_clr !== 6'b000000 || busy !== 1'b1) begin
            n_fails++;
            $display("FAIL fixed_wait: got clr=%b busy=%0b, expected 000000 1", flag_clr, busy);
        end
        @(negedge clk);
        n_checks++;
        if (irq_req !== 1'b0) begin
            n_fails++;
            $display("FAIL fixed_idle_gap: got req=%0b, expected 0", irq_req);
        end
        @(negedge clk);
        n_checks++;
        if (irq_req !== 1'b1 || irq_vec !== 3'd5) begin
            n_fails++;
            $display("FAIL fixed_second: got req=%0b vec=%0d, expected 1 5", irq_req, irq_vec);
        end
        irq_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (flag_clr !== 6'b100000) begin
            n_fails++;
            $display("FAIL fixed_clr5: got clr=%b, expected 100000", flag_clr);
        end
        irq_ack = 1'b0;
        irq_src = 6'b000000;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++;
            $display("FAIL fixed_done: got busy=%0b, expected 0", busy);
        end
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_g;
        logic [5:0] exp_oh;
        rr_en   = 1'b1;
        irq_src = 6'h3F;
        for (int k = 0; k < 7; k++) begin
            exp_g  = 3'(k % 6);
            exp_oh = 6'b000001 << exp_g;
            @(negedge clk);
            n_checks++;
            if (irq_req !== 1'b1 || irq_vec !== exp_g) begin
                n_fails++;
                $display("FAIL rr_grant[%0d]: got req=%0b vec=%0d, expected 1 %0d", k, irq_req, irq_vec, exp_g);
            end
            irq_ack = 1'b1;
            @(negedge clk);
            n_checks++;
            if (flag_clr !== exp_oh || irq_req !== 1'b0) begin
                n_fails++;
                $display("FAIL rr_clr[%0d]: got clr=%b req=%0b, expected %b 0", k, flag_clr, irq_req, exp_oh);
            end
            irq_ack = 1'b0;
            irq_src = irq_src & ~exp_oh;
            @(negedge clk);
            n_checks++;
            if (irq_req !== 1'b0 || flag_clr !== 6'b000000) begin
                n_fails++;
                $display("FAIL rr_wait[%0d]: got req=%0b clr=%b, expected 0 000000", k, irq_req, flag_clr);
            end
            @(negedge clk);
            n_checks++;
            if (irq_req !== 1'b0 || busy !== 1'b0) begin
                n_fails++;
                $display("FAIL rr_idle[%0d]: got req=%0b busy=%0b, expected 0 0", k, irq_req, busy);
            end
            irq_src = (k == 6) ? 6'h00 : 6'h3F;
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++;
            $display("FAIL rr_done: got busy=%0b, expected 0", busy);
        end
    endtask

    task automatic test_withdraw;
        rr_en   = 1'b0;
        irq_src = 6'b010000;
        @(negedge clk);
        n_checks++;
        if (irq_req !== 1'b1 || irq_vec !== 3'd4) begin
            n_fails++;
            $display("FAIL wd_grant: got req=%0b vec=%0d, expected 1 4", irq_req, irq_vec);
        end
        irq_src = 6'b000000;
        @(negedge clk);
        n_checks++;
        if (irq_req !== 1'b0 || flag_clr !== 6'b000000 || timeout_err !== 1'b0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL wd_cancel: got req=%0b clr=%b to=%0b busy=%0b, expected 0 000000 0 0",
                     irq_req, flag_clr, timeout_err, busy);
        end
    endtask

    task automatic test_timeout;
        logic       exp_to;
        logic       exp_req;
        logic [2:0] exp_vec;
        rr_en   = 1'b1;
        irq_src = 6'b000010;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            exp_to  = (c == 10) || (c == 20);
            exp_req = !exp_to;
            exp_vec = (c == 21) ? 3'd3 : (exp_req ? 3'd1 : 3'd0);
            n_checks++;
            if (timeout_err !== exp_to || irq_req !== exp_req || irq_vec !== exp_vec) begin
                n_fails++;
                $display("FAIL timeout_cyc[%0d]: got to=%0b req=%0b vec=%0d, expected %0b %0b %0d",
                         c, timeout_err, irq_req, irq_vec, exp_to, exp_req, exp_vec);
            end
            if (c == 11) irq_src = 6'b001010;
        end
        irq_src = 6'b000000;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            n_fails++;
            $display("FAIL timeout_done: got busy=%0b to=%0b, expected 0 0", busy, timeout_err);
        end
    endtask

    task automatic test_mask_stray_ack;
        rr_en   = 1'b0;
        irq_en  = 6'h00;
        irq_src = 6'h01;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (irq_req !== 1'b0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL mask_block: got req=%0b busy=%0b, expected 0 0", irq_req, busy);
        end
        irq_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (flag_clr !== 6'b000000 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL stray_ack: got clr=%b busy=%0b, expected 000000 0", flag_clr, busy);
        end
        irq_ack = 1'b0;
        irq_en  = 6'h01;
        @(negedge clk);
        n_checks++;
        if (irq_req !== 1'b1 || irq_vec !== 3'd0) begin
            n_fails++;
            $display("FAIL mask_enable: got req=%0b vec=%0d, expected 1 0", irq_req, irq_vec);
        end
        irq_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (flag_clr !== 6'b000001) begin
            n_fails++;
            $display("FAIL mask_clr: got clr=%b, expected 000001", flag_clr);
        end
        irq_ack = 1'b0;
        irq_src = 6'h00;
        irq_en  = 6'h3F;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_req;
        rr_en   = 1'b1;
        irq_src = 6'b100000;
        @(negedge clk);
        n_checks++;
        if (irq_req !== 1'b1 || irq_vec !== 3'd5) begin
            n_fails++;
            $display("FAIL rst_pre: got req=%0b vec=%0d, expected 1 5", irq_req, irq_vec);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (irq_req !== 1'b0 || busy !== 1'b0 || irq_vec !== 3'd0) begin
            n_fails++;
            $display("FAIL rst_async: got req=%0b busy=%0b vec=%0d, expected 0 0 0", irq_req, busy, irq_vec);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        irq_src = 6'b100001;
        @(negedge clk);
        n_checks++;
        if (irq_req !== 1'b1 || irq_vec !== 3'd0) begin
            n_fails++;
            $display("FAIL rst_restart: got req=%0b vec=%0d, expected 1 0", irq_req, irq_vec);
        end
        irq_src = 6'b000000;
    endtask

    initial begin
        rst_n   = 1'b0;
        irq_src = '0;
        irq_en  = '0;
        rr_en   = 1'b0;
        irq_ack = 1'b0;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_withdraw();
        test_timeout();
        test_mask_stray_ack();
        test_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/timer_irq_arbiter.md
Name: timer_irq_arbiter

Overview:
- Sequences the six timer interrupt sources (CMIA0, CMIB0, OVI0, CMIA1, CMIB1, OVI1) onto the single CPU interrupt line.
- Selects one pending source and presents it with a vector, then waits for the CPU acknowledge.
- On acknowledge, issues a one-cycle flag-clear pulse back to the TCSR flag logic and waits for the flag to drop before arbitrating again.
- Sits between the timer ControlLogic interrupt outputs and the CPU interrupt controller.

Parameters:
- NUM_SRC, 6: number of interrupt sources; legal range 2..8. Index order is {OVI1, CMIB1, CMIA1, OVI0, CMIB0, CMIA0}, with index 0 = CMIA0.
- VEC_WIDTH, 3: width of irq_vec; must satisfy 2^VEC_WIDTH >= NUM_SRC.
- ACK_TIMEOUT, 255: cycles allowed in REQ or WAIT before abort. 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq_src  in  NUM_SRC  level interrupt requests (flag AND enable, from ControlLogic).
- irq_en  in  NUM_SRC  per-source arbiter enable; a source counts as pending only when irq_src[i] & irq_en[i].
- rr_en  in  1  0 = fixed priority (index 0 highest); 1 = round-robin.
- irq_ack  in  1  CPU acknowledge, sampled only in REQ.
- irq_req  out  1  interrupt request to the CPU.
- irq_vec  out  VEC_WIDTH  index of the granted source; valid while irq_req=1.
- flag_clr  out  NUM_SRC  one-hot, one-cycle clear pulse to the TCSR flag of the granted source.
- timeout_err  out  1  one-cycle pulse on timeout abort.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, rr_ptr=0, timer=0. All outputs are 0, and irq_vec=0.
- The timer counter has width $clog2(ACK_TIMEOUT+1). It clears on every state change.
- State IDLE:
  - pending = irq_src & irq_en.
  - If pending != 0 at an edge: latch the winner into grant and go to REQ.
  - Fixed mode winner: lowest set index.
  - Round-robin mode winner: first set index scanning rr_ptr, rr_ptr+1, ... mod NUM_SRC.
- State REQ:
  - irq_req=1 and irq_vec=grant, both registered. irq_req rises one cycle after the edge that first samples the source.
  - irq_vec is stable for the whole REQ stay. A higher-priority source arriving later does not pre-empt the grant.
  - If irq_ack=1: go to CLR.
  - Else if pending[grant]=0 (source withdrawn or disabled): go to IDLE. This is a silent cancel with no flag_clr and no timeout_err. Withdrawal takes precedence over timeout.
  - Else if ACK_TIMEOUT != 0 and timer reaches ACK_TIMEOUT: pulse timeout_err, advance rr_ptr to grant+1 mod NUM_SRC, go to IDLE.
  - If ack and withdrawal coincide, ack wins and the state goes to CLR.
- State CLR (exactly 1 cycle):
  - irq_req=0, flag_clr[grant]=1.
  - rr_ptr <= grant+1 mod NUM_SRC; the wrap from NUM_SRC-1 goes to 0.
  - Next state is WAIT.
- State WAIT:
  - flag_clr=0, irq_req=0.
  - If irq_src[grant]=0: go to IDLE.
  - Else if the timer reaches ACK_TIMEOUT (and ACK_TIMEOUT != 0): pulse timeout_err and go to IDLE.
- irq_ack outside REQ is ignored.
- Changes to rr_en take effect at the next IDLE arbitration.
- Throughput: the minimum turnaround from ack to the next irq_req is 4 cycles (CLR, WAIT, IDLE, REQ), given the flag drops within one cycle of flag_clr.
- Reset mid-operation forces IDLE immediately; any in-flight flag_clr pulse is truncated.
- flag_clr is never asserted for more than one bit or for more than one cycle per grant.

Test Plan:
- Fixed priority, simultaneous sources: rr_en=0, irq_en=6'h3F, irq_src=6'b100100. Required: irq_req=1 with irq_vec=2. After irq_ack, flag_clr=6'b000100 for one cycle. Once bit 2 drops, a second request follows with irq_vec=5.
- Round-robin fairness: rr_en=1, irq_src=6'h3F held, immediate ack with each flag cleared one cycle later. Required: grant sequence 0,1,2,3,4,5,0. irq_req rises every 4th cycle after the first ack.
- Withdrawal: grant index 4, then deassert irq_src[4] before ack. Required: irq_req drops next cycle, flag_clr stays 0, timeout_err stays 0, busy returns to 0.
- Timeout: ACK_TIMEOUT=8, irq_src[1] held, no ack. Required: timeout_err pulses once, 9 cycles after entering REQ. With rr_en=1 the next grant is a higher index if one is pending, otherwise index 1 again.
- Masking and stray ack: irq_src=6'h01 with irq_en=6'h00 gives no irq_req. An irq_ack pulse in IDLE causes no flag_clr. Setting irq_en[0]=1 gives irq_req the next cycle with irq_vec=0.
- Reset mid-REQ: assert rst_n=0 asynchronously while in REQ. Required: irq_req, busy and irq_vec go to 0 without waiting for a clk edge. After release, arbitration restarts from rr_ptr=0.
